// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared constants and state encoding for the ROM boot loader
package rom_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         WORD_W    = 32;
  localparam int         ADDR_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } ldr_state_e;

  function automatic logic in_frame(input ldr_state_e s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/rom_loader_timeout.sv
// rtl/rom_loader_timeout.sv - inter-byte idle counter; expires after CYCLES-1 idle cycles
module rom_loader_timeout #(
  parameter int CYCLES = 1000000,
  parameter int W      = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && !clr_i && (cnt_q == W'(CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - byte-stream boot loader writing checksum-verified images into the instruction ROM
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int                ROM_DEPTH         = 256,
  parameter int                ROM_DEPTH_BIT_LEN = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR         = 32'h0,
  parameter int                TIMEOUT_CYCLES    = 1000000,
  parameter int                TIMEOUT_BIT_LEN   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              w_en_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [WORD_W-1:0] w_data_o,
  output logic [3:0]        w_sel_o,
  output logic              hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int          CW        = ROM_DEPTH_BIT_LEN + 2;
  localparam logic [16:0] MAX_BYTES = 17'(ROM_DEPTH * 4);

  ldr_state_e        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [WORD_W-1:0] stage_q, stage_d;
  logic [3:0]        mask_q, mask_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [WORD_W-1:0] w_data_q, w_data_d;
  logic [3:0]        w_sel_q, w_sel_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              expired;
  logic [1:0]        lane;
  logic              last_byte;
  logic [15:0]       n_full;

  rom_loader_timeout #(
    .CYCLES (TIMEOUT_CYCLES),
    .W      (TIMEOUT_BIT_LEN)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (rx_valid_i || !in_frame(state_q)),
    .en_i      (in_frame(state_q)),
    .expired_o (expired)
  );

  assign lane      = cnt_q[1:0];
  assign last_byte = (16'(cnt_q) == (len_q - 16'd1));
  assign n_full    = {rx_data_i, len_q[7:0]};

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    stage_d  = stage_q;
    mask_d   = mask_q;
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    w_sel_d  = w_sel_q;
    hold_d   = hold_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid_i && rx_data_i == SYNC_BYTE) begin
          state_d = ST_LEN0;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          csum_d  = '0;
          cnt_d   = '0;
          stage_d = '0;
          mask_d  = '0;
        end
      end
      ST_LEN0: begin
        if (rx_valid_i) begin
          len_d   = {8'h00, rx_data_i};
          state_d = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (rx_valid_i) begin
          len_d = n_full;
          if (n_full == 16'd0) begin
            state_d = ST_CHECK;
          end else if ({1'b0, n_full} > MAX_BYTES) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid_i) begin
          stage_d = stage_q | (WORD_W'(rx_data_i) << {lane, 3'b000});
          mask_d  = mask_q | (4'b0001 << lane);
          csum_d  = csum_q ^ rx_data_i;
          cnt_d   = cnt_q + 1'b1;
          // The write register is separate from staging, so the next byte may land next cycle.
          if (lane == 2'd3 || last_byte) begin
            w_en_d   = 1'b1;
            w_data_d = stage_d;
            w_sel_d  = mask_d;
            w_addr_d = BASE_ADDR + ADDR_W'({cnt_q[CW-1:2], 2'b00});
            stage_d  = '0;
            mask_d   = '0;
          end
          if (last_byte) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (rx_valid_i) begin
          state_d = (rx_data_i == csum_q) ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (expired) begin
      state_d = ST_ERR;
      stage_d = '0;
      mask_d  = '0;
    end

    if (state_d == ST_ERR) begin
      err_d = 1'b1;
    end
    done_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      hold_d = 1'b0;
    end
    busy_d = in_frame(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      csum_q   <= '0;
      stage_q  <= '0;
      mask_q   <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= BASE_ADDR;
      w_data_q <= '0;
      w_sel_q  <= '0;
      hold_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      stage_q  <= stage_d;
      mask_q   <= mask_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_sel_q  <= w_sel_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign w_en_o   = w_en_q;
  assign w_addr_o = w_addr_q;
  assign w_data_o = w_data_q;
  assign w_sel_o  = w_sel_q;
  assign hold_o   = hold_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - directed bench for rom_loader
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        w_en_o;
  logic [31:0] w_addr_o;
  logic [31:0] w_data_o;
  logic [3:0]  w_sel_o;
  logic        hold_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int n_total = 0;
  int n_bad   = 0;

  logic [67:0] wq[$];
  int          done_cnt = 0;

  rom_loader #(
    .ROM_DEPTH         (256),
    .ROM_DEPTH_BIT_LEN (8),
    .BASE_ADDR         (32'h0),
    .TIMEOUT_CYCLES    (40),
    .TIMEOUT_BIT_LEN   (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .w_en_o     (w_en_o),
    .w_addr_o   (w_addr_o),
    .w_data_o   (w_data_o),
    .w_sel_o    (w_sel_o),
    .hold_o     (hold_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_en_o) wq.push_back({w_addr_o, w_data_o, w_sel_o});
    if (done_o) done_cnt++;
  end

  task automatic expect_eq(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [67:0] w_at(input int i);
    return (i < wq.size()) ? wq[i] : {68{1'b1}};
  endfunction

  task automatic send(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_all(input logic [7:0] fr[$]);
    foreach (fr[i]) send(fr[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    expect_eq({pfx, "_w_en"},   68'(w_en_o),   68'd0);
    expect_eq({pfx, "_w_addr"}, 68'(w_addr_o), 68'h0);
    expect_eq({pfx, "_w_data"}, 68'(w_data_o), 68'h0);
    expect_eq({pfx, "_w_sel"},  68'(w_sel_o),  68'h0);
    expect_eq({pfx, "_hold"},   68'(hold_o),   68'd1);
    expect_eq({pfx, "_busy"},   68'(busy_o),   68'd0);
    expect_eq({pfx, "_done"},   68'(done_o),   68'd0);
    expect_eq({pfx, "_err"},    68'(err_o),    68'd0);
  endtask

  int          wb;
  int          db;
  logic [7:0]  fr[$];
  logic [7:0]  stream[$];

  initial begin
    idle(2);
    rst_n = 1'b1;
    check_reset_values("rst");

    // 1: two full words; checksum of 11..88 is 0x88
    wb = wq.size(); db = done_cnt;
    send(8'hA5);
    expect_eq("t1_busy_after_sync", 68'(busy_o), 68'd1);
    expect_eq("t1_hold_in_frame",   68'(hold_o), 68'd1);
    fr = '{8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    send_all(fr);
    idle(3);
    expect_eq("t1_nwrites", 68'(wq.size() - wb), 68'd2);
    expect_eq("t1_w0", w_at(wb),     {32'h0, 32'h44332211, 4'hF});
    expect_eq("t1_w1", w_at(wb + 1), {32'h4, 32'h88776655, 4'hF});
    expect_eq("t1_done_cycles", 68'(done_cnt - db), 68'd1);
    expect_eq("t1_hold", 68'(hold_o), 68'd0);
    expect_eq("t1_busy", 68'(busy_o), 68'd0);
    expect_eq("t1_err",  68'(err_o),  68'd0);

    // 2: partial final word, plus write strobe latency
    wb = wq.size(); db = done_cnt;
    fr = '{8'hA5, 8'h03, 8'h00, 8'hAA, 8'hBB};
    send_all(fr);
    expect_eq("t2_wen_before_last", 68'(w_en_o), 68'd0);
    send(8'hCC);
    expect_eq("t2_wen_after_last", 68'(w_en_o), 68'd1);
    send(8'hDD);
    idle(3);
    expect_eq("t2_nwrites", 68'(wq.size() - wb), 68'd1);
    expect_eq("t2_w0", w_at(wb), {32'h0, 32'h00CCBBAA, 4'b0111});
    expect_eq("t2_done_cycles", 68'(done_cnt - db), 68'd1);

    // 3: bad checksum
    wb = wq.size(); db = done_cnt;
    fr = '{8'hA5, 8'h01, 8'h00, 8'h5A, 8'h00};
    send_all(fr);
    idle(3);
    expect_eq("t3_nwrites", 68'(wq.size() - wb), 68'd1);
    expect_eq("t3_w0", w_at(wb), {32'h0, 32'h0000005A, 4'b0001});
    expect_eq("t3_err",  68'(err_o),  68'd1);
    expect_eq("t3_hold", 68'(hold_o), 68'd1);
    expect_eq("t3_done_cycles", 68'(done_cnt - db), 68'd0);

    // 4: N = 1025 exceeds 1024-byte ROM
    wb = wq.size(); db = done_cnt;
    fr = '{8'hA5, 8'h01, 8'h04};
    send_all(fr);
    idle(3);
    expect_eq("t4_err",     68'(err_o),  68'd1);
    expect_eq("t4_hold",    68'(hold_o), 68'd1);
    expect_eq("t4_busy",    68'(busy_o), 68'd0);
    expect_eq("t4_nwrites", 68'(wq.size() - wb), 68'd0);

    // 5: timeout mid-word, then recovery with a good frame
    wb = wq.size(); db = done_cnt;
    send(8'hA5);
    expect_eq("t5_err_cleared_by_sync", 68'(err_o), 68'd0);
    fr = '{8'h04, 8'h00, 8'h01, 8'h02};
    send_all(fr);
    for (int i = 0; i < 200 && !err_o; i++) @(posedge clk);
    #1;
    expect_eq("t5_timeout_err", 68'(err_o), 68'd1);
    idle(2);
    expect_eq("t5_timeout_nwrites", 68'(wq.size() - wb), 68'd0);
    fr = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h20, 8'h30};
    send_all(fr);
    idle(3);
    expect_eq("t5_err_after_good", 68'(err_o), 68'd0);
    expect_eq("t5_nwrites", 68'(wq.size() - wb), 68'd1);
    expect_eq("t5_w0", w_at(wb), {32'h0, 32'h00002010, 4'b0011});
    expect_eq("t5_done_cycles", 68'(done_cnt - db), 68'd1);
    expect_eq("t5_hold", 68'(hold_o), 68'd0);

    // 6: back-to-back stream, reset pulsed after the sixth byte
    wb = wq.size();
    stream = '{8'hA5, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h01, 8'h02,
               8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        rx_valid_i = 1'b1;
        rx_data_i  = stream[i];
        #5;
        expect_eq("t6_nwrites_before_rst", 68'(wq.size() - wb), 68'd1);
        expect_eq("t6_w0", w_at(wb), {32'h0, 32'h00CCBBAA, 4'b0111});
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end else begin
        send(stream[i]);
      end
    end
    idle(3);
    expect_eq("t6_nwrites_after_rst", 68'(wq.size() - wb), 68'd1);
    check_reset_values("t6");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
